// File: rtl/xgmm_pkg.sv
// Shared types and sizing constants for the VRAM writer drain stage.
package xgmm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        P_POP,
        P_WR,
        A_POP,
        A_WR
    } xgmm_wr_state_t;

    typedef enum logic {
        PAT,
        ATTR
    } src_t;

    localparam int WORDS_PER_RUN = 4;
    localparam int RUNS_PER_TILE = 4;

endpackage

// File: rtl/xgmm_burst_pack.sv
// Four 16-bit lane registers gathered into one 64-bit burst word.
module xgmm_burst_pack (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        load,
    input  logic [1:0]  lane_idx,
    input  logic [15:0] din,
    output logic [63:0] data
);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [15:0] lane_q;
            logic [15:0] lane_d;

            always_comb begin
                lane_d = lane_q;
                if (load && (lane_idx == 2'(gi))) begin
                    lane_d = din;
                end
            end

            always_ff @(posedge clk_sys or posedge rst) begin
                if (rst) begin
                    lane_q <= '0;
                end else begin
                    lane_q <= lane_d;
                end
            end

            assign data[16*gi +: 16] = lane_q;
        end
    endgenerate

endmodule

// File: rtl/xgmm_vram_writer.sv
// Drains pattern tiles (4 runs of 4 words) and attribute groups (1 run of 4
// words) from the register-interface FIFOs into 64-bit VRAM write bursts.
module xgmm_vram_writer
    import xgmm_pkg::*;
#(
    parameter int                ADDR_W    = 22,
    parameter logic [ADDR_W-1:0] PAT_BASE  = 22'h000000,
    parameter logic [ADDR_W-1:0] ATTR_BASE = 22'h010000
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              drain_en,
    input  logic              p_full,
    input  logic              a_full,
    input  logic [15:0]       p_data,
    input  logic [15:0]       a_data,
    input  logic [11:0]       par,
    input  logic [14:0]       aar,
    output logic              p_pop,
    output logic              a_pop,
    output logic              vram_wr_req,
    input  logic              vram_wr_ack,
    output logic [ADDR_W-1:0] vram_wr_addr,
    output logic [63:0]       vram_wr_data,
    output logic              busy
);

    xgmm_wr_state_t    state_q, state_d;
    src_t              last_q, last_d;
    logic [1:0]        run_idx_q, run_idx_d;
    logic [1:0]        word_idx_q, word_idx_d;
    logic [ADDR_W-1:0] pat_base_q, pat_base_d;
    logic [ADDR_W-1:0] attr_q, attr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              p_pop_q, p_pop_d;
    logic              a_pop_q, a_pop_d;
    logic              req_q, req_d;
    logic              busy_q, busy_d;

    logic              pack_load;
    logic [15:0]       pack_din;

    // A pop cycle samples the FIFO head into the lane selected by word_idx.
    assign pack_load = (state_q == P_POP) || (state_q == A_POP);
    assign pack_din  = (state_q == P_POP) ? p_data : a_data;

    xgmm_burst_pack u_pack (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .load     (pack_load),
        .lane_idx (word_idx_q),
        .din      (pack_din),
        .data     (vram_wr_data)
    );

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        run_idx_d  = run_idx_q;
        word_idx_d = word_idx_q;
        pat_base_d = pat_base_q;
        attr_d     = attr_q;
        addr_d     = addr_q;
        req_d      = req_q;
        p_pop_d    = 1'b0;
        a_pop_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // When both FIFOs are full, serve the source not served last.
                if (drain_en && p_full && (!a_full || last_q == ATTR)) begin
                    state_d    = P_POP;
                    p_pop_d    = 1'b1;
                    word_idx_d = '0;
                    run_idx_d  = '0;
                    pat_base_d = PAT_BASE + ADDR_W'({par, 4'b0000});
                end else if (drain_en && a_full && (!p_full || last_q == PAT)) begin
                    state_d    = A_POP;
                    a_pop_d    = 1'b1;
                    word_idx_d = '0;
                    attr_d     = ATTR_BASE + ADDR_W'({aar[14:2], 2'b00});
                end
            end
            P_POP: begin
                word_idx_d = word_idx_q + 2'd1;
                if (word_idx_q == 2'(WORDS_PER_RUN - 1)) begin
                    state_d = P_WR;
                    req_d   = 1'b1;
                    addr_d  = pat_base_q + ADDR_W'({run_idx_q, 2'b00});
                end else begin
                    p_pop_d = 1'b1;
                end
            end
            P_WR: begin
                // The write cycle doubles as the p_pop gap that upstream counts.
                if (vram_wr_ack) begin
                    req_d = 1'b0;
                    if (run_idx_q == 2'(RUNS_PER_TILE - 1)) begin
                        run_idx_d = '0;
                        last_d    = PAT;
                        state_d   = IDLE;
                    end else begin
                        run_idx_d  = run_idx_q + 2'd1;
                        word_idx_d = '0;
                        p_pop_d    = 1'b1;
                        state_d    = P_POP;
                    end
                end
            end
            A_POP: begin
                word_idx_d = word_idx_q + 2'd1;
                if (word_idx_q == 2'(WORDS_PER_RUN - 1)) begin
                    state_d = A_WR;
                    req_d   = 1'b1;
                    addr_d  = attr_q;
                end else begin
                    a_pop_d = 1'b1;
                end
            end
            A_WR: begin
                if (vram_wr_ack) begin
                    req_d   = 1'b0;
                    last_d  = ATTR;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= ATTR;
            run_idx_q  <= '0;
            word_idx_q <= '0;
            pat_base_q <= '0;
            attr_q     <= '0;
            addr_q     <= '0;
            p_pop_q    <= 1'b0;
            a_pop_q    <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            run_idx_q  <= run_idx_d;
            word_idx_q <= word_idx_d;
            pat_base_q <= pat_base_d;
            attr_q     <= attr_d;
            addr_q     <= addr_d;
            p_pop_q    <= p_pop_d;
            a_pop_q    <= a_pop_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
        end
    end

    assign p_pop        = p_pop_q;
    assign a_pop        = a_pop_q;
    assign vram_wr_req  = req_q;
    assign vram_wr_addr = addr_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_xgmm_vram_writer.sv
// Randomized bench: FIFO/VRAM models plus a queue-based reference of expected writes.
module tb_xgmm_vram_writer;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b0;
    logic        drain_en = 1'b0;
    logic        vram_wr_ack = 1'b0;
    logic [11:0] par = '0;
    logic [14:0] aar = '0;
    logic        p_full, a_full, p_pop, a_pop, vram_wr_req, busy;
    logic [15:0] p_data, a_data;
    logic [21:0] vram_wr_addr;
    logic [63:0] vram_wr_data;

    always #5 clk_sys = ~clk_sys;

    xgmm_vram_writer dut (
        .clk_sys      (clk_sys),
        .rst          (rst),
        .drain_en     (drain_en),
        .p_full       (p_full),
        .a_full       (a_full),
        .p_data       (p_data),
        .a_data       (a_data),
        .par          (par),
        .aar          (aar),
        .p_pop        (p_pop),
        .a_pop        (a_pop),
        .vram_wr_req  (vram_wr_req),
        .vram_wr_ack  (vram_wr_ack),
        .vram_wr_addr (vram_wr_addr),
        .vram_wr_data (vram_wr_data),
        .busy         (busy)
    );

    // Upstream FIFO models: head valid combinationally, advance on the pop edge.
    logic [15:0] pmem [256];
    logic [15:0] amem [256];
    int p_wr = 0, a_wr = 0, p_rd = 0, a_rd = 0, under = 0;

    assign p_data = pmem[p_rd[7:0]];
    assign a_data = amem[a_rd[7:0]];
    assign p_full = ((p_wr - p_rd) >= 16);
    assign a_full = ((a_wr - a_rd) >= 4);

    always @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            p_rd <= 0;
            a_rd <= 0;
        end else begin
            if (p_pop) begin
                if (p_rd >= p_wr) under <= under + 1;
                p_rd <= p_rd + 1;
            end
            if (a_pop) begin
                if (a_rd >= a_wr) under <= under + 1;
                a_rd <= a_rd + 1;
            end
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: words waiting in each FIFO and the arbitration history.
    typedef struct {
        logic [21:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         expq [$];
    logic [15:0] mp [$];
    logic [15:0] ma [$];
    bit          last_attr = 1'b1;

    task automatic fill(input int np, input int na, input int pbase);
        logic [15:0] w;
        for (int i = 0; i < np; i++) begin
            w = (pbase >= 0) ? 16'(pbase + i) : 16'($urandom);
            pmem[p_wr % 256] = w;
            p_wr++;
            mp.push_back(w);
        end
        for (int i = 0; i < na; i++) begin
            w = 16'($urandom);
            amem[a_wr % 256] = w;
            a_wr++;
            ma.push_back(w);
        end
    endtask

    task automatic plan();
        wr_t e;
        while (mp.size() >= 16 || ma.size() >= 4) begin
            if (mp.size() >= 16 && (ma.size() < 4 || last_attr)) begin
                for (int r = 0; r < 4; r++) begin
                    e.addr = 22'(int'(par) * 16 + r * 4);
                    for (int i = 0; i < 4; i++) e.data[16*i +: 16] = mp.pop_front();
                    expq.push_back(e);
                end
                last_attr = 1'b0;
            end else begin
                e.addr = 22'('h010000 + (int'(aar) / 4) * 4);
                for (int i = 0; i < 4; i++) e.data[16*i +: 16] = ma.pop_front();
                expq.push_back(e);
                last_attr = 1'b1;
            end
        end
    endtask

    // VRAM port model and protocol monitor, all sampled on the falling edge.
    int          cnt = 0, ack_delay = 0, force_delay = -1;
    int          prun = 0, arun = 0, pops = 0, wr_seen = 0;
    bit          prev_req = 1'b0;
    logic [21:0] h_addr;
    logic [63:0] h_data;
    wr_t         mon_e;

    always @(negedge clk_sys) begin
        if (rst) begin
            vram_wr_ack = 1'b0;
            cnt = 0;
            prun = 0;
            arun = 0;
            prev_req = 1'b0;
        end else begin
            if (p_pop) begin
                prun++;
                pops++;
            end else if (prun > 0) begin
                chk("p_run_len", 64'(prun), 64'd4);
                prun = 0;
            end
            if (a_pop) begin
                arun++;
                pops++;
            end else if (arun > 0) begin
                chk("a_run_len", 64'(arun), 64'd4);
                arun = 0;
            end
            if (vram_wr_req) begin
                if (!prev_req) begin
                    h_addr = vram_wr_addr;
                    h_data = vram_wr_data;
                    cnt = 0;
                    ack_delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                end else begin
                    chk("hold_addr", 64'(vram_wr_addr), 64'(h_addr));
                    chk("hold_data", vram_wr_data, h_data);
                end
                chk("pop_in_wr", 64'({p_pop, a_pop}), 64'd0);
                chk("busy_in_wr", 64'(busy), 64'd1);
                vram_wr_ack = (cnt >= ack_delay);
                cnt++;
                if (vram_wr_ack) begin
                    wr_seen++;
                    chk("wr_expected", 64'(expq.size() > 0), 64'd1);
                    if (expq.size() > 0) begin
                        mon_e = expq.pop_front();
                        chk("wr_addr", 64'(vram_wr_addr), 64'(mon_e.addr));
                        chk("wr_data", vram_wr_data, mon_e.data);
                        $display("write addr=%06h data=%016h held=%0d", vram_wr_addr, vram_wr_data, cnt);
                    end
                end
            end else begin
                // Stray acks while no request is pending must be ignored.
                vram_wr_ack = ($urandom_range(0, 3) == 0);
            end
            prev_req = vram_wr_req;
        end
    end

    task automatic do_reset();
        @(negedge clk_sys);
        rst = 1'b1;
        drain_en = 1'b0;
        p_wr = 0;
        a_wr = 0;
        mp.delete();
        ma.delete();
        expq.delete();
        last_attr = 1'b1;
        repeat (2) @(negedge clk_sys);
        rst = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        plan();
        drain_en = 1'b1;
        @(negedge clk_sys);
        while ((expq.size() != 0 || busy) && n < 3000) begin
            @(negedge clk_sys);
            n++;
        end
        drain_en = 1'b0;
        chk({tag, "_done"}, 64'(n < 3000), 64'd1);
        chk({tag, "_p_left"}, 64'(p_wr - p_rd), 64'(mp.size()));
        chk({tag, "_a_left"}, 64'(a_wr - a_rd), 64'(ma.size()));
        @(negedge clk_sys);
    endtask

    initial begin
        int n, k, w0, pc;

        do_reset();
        chk("rst_ctrl", 64'({p_pop, a_pop, vram_wr_req, busy}), 64'd0);
        chk("rst_addr", 64'(vram_wr_addr), 64'd0);
        chk("rst_data", vram_wr_data, 64'd0);

        par = 12'h005;
        fill(16, 0, 'h1000);
        drain("pat_dir");

        aar = 15'h0102;
        fill(0, 4, -1);
        drain("attr_dir");

        do_reset();
        fill(16, 4, -1);
        drain("both1");
        fill(32, 8, -1);
        drain("both2");

        force_delay = 5;
        fill(16, 4, -1);
        drain("slow_ack");
        force_delay = -1;

        // Drain disabled: nothing moves; then drop the enable mid-tile.
        fill(16, 0, -1);
        pc = pops;
        repeat (20) @(negedge clk_sys);
        chk("dis_pops", 64'(pops - pc), 64'd0);
        chk("dis_busy", 64'(busy), 64'd0);
        w0 = wr_seen;
        plan();
        drain_en = 1'b1;
        n = 0;
        while (!(wr_seen > w0 && p_pop) && n < 200) begin
            @(negedge clk_sys);
            n++;
        end
        chk("run2_seen", 64'(n < 200), 64'd1);
        drain_en = 1'b0;
        n = 0;
        while ((expq.size() != 0 || busy) && n < 500) begin
            @(negedge clk_sys);
            n++;
        end
        chk("en_drop_writes", 64'(wr_seen - w0), 64'd4);

        for (int it = 0; it < 8; it++) begin
            par = 12'($urandom);
            aar = 15'($urandom);
            fill(int'($urandom_range(0, 2)) * 16 + int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)) * 4, -1);
            drain("rand");
        end

        // Reset during the third pop of a run abandons the burst.
        do_reset();
        fill(16, 0, -1);
        plan();
        drain_en = 1'b1;
        k = 0;
        n = 0;
        while (k < 3 && n < 100) begin
            @(negedge clk_sys);
            if (p_pop) k++;
            n++;
        end
        chk("rst_mid_reached", 64'(k), 64'd3);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_ctrl", 64'({p_pop, vram_wr_req, busy}), 64'd0);
        p_wr = 0;
        mp.delete();
        expq.delete();
        last_attr = 1'b1;
        repeat (2) @(negedge clk_sys);
        rst = 1'b0;
        w0 = wr_seen;
        pc = pops;
        repeat (30) @(negedge clk_sys);
        chk("post_rst_wr", 64'(wr_seen - w0), 64'd0);
        chk("post_rst_pops", 64'(pops - pc), 64'd0);
        drain_en = 1'b0;

        chk("fifo_underflow", 64'(under), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xgmm_vram_writer.md
Name: xgmm_vram_writer

Overview:
Downstream drain stage of the graphics register interface. Pops 16-word pattern tiles and 4-word attribute groups out of the register interface's p/a FIFOs and issues them as 64-bit write bursts to the VRAM (SDRAM) write port. Uses the current pattern/attribute address registers (par/aar) to form VRAM addresses. Pop timing is shaped so that the upstream address auto-increment logic advances correctly.

Parameters:
ADDR_W, 22, VRAM word (16-bit) address width
PAT_BASE, 22'h000000, VRAM word address of pattern tile 0
ATTR_BASE, 22'h010000, VRAM word address of attribute word 0

Ports:
clk_sys  in  1  system clock
rst  in  1  asynchronous active-high reset
drain_en  in  1  drain permitted (video blanking window); sampled only in IDLE
p_full  in  1  pattern FIFO holds 16 words (one tile)
a_full  in  1  attribute FIFO holds 4 words
p_data  in  16  pattern FIFO head word, valid combinationally
a_data  in  16  attribute FIFO head word, valid combinationally
par  in  12  current pattern tile address
aar  in  15  current attribute word address
p_pop  out  1  pattern FIFO pop
a_pop  out  1  attribute FIFO pop
vram_wr_req  out  1  write request; held until ack
vram_wr_ack  in  1  write accepted this cycle
vram_wr_addr  out  ADDR_W  word address of first word of burst
vram_wr_data  out  64  burst data, word i at bits [16i+15:16i]
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE, all outputs 0, run_idx 0, word_idx 0, last_served = ATTR. Data and address registers are cleared. A reset mid-burst abandons the burst; the upstream FIFOs reset on the same rst.
- Clock domain: single clock, clk_sys.
- States: IDLE, P_POP, P_WR, A_POP, A_WR.
- IDLE -> P_POP when drain_en & p_full and (~a_full or last_served==ATTR).
- IDLE -> A_POP when drain_en & a_full and (~p_full or last_served==PAT).
- On IDLE exit, latch the base address:
  - pattern: pat_base_q = PAT_BASE + {par, 4'b0000}
  - attribute: attr_q = ATTR_BASE + {aar[14:2], 2'b00}; aar[1:0] is ignored.
- P_POP: p_pop=1 for exactly 4 consecutive cycles (word_idx 0..3). Each cycle, capture p_data into lane word_idx. Go to P_WR after the 4th pop; p_pop is 0 in P_WR.
- P_WR:
  - vram_wr_req=1, vram_wr_addr = pat_base_q + {run_idx, 2'b00}.
  - On ack: req drops next cycle. If run_idx==3, set run_idx=0, last_served=PAT, go to IDLE. Otherwise increment run_idx and return to P_POP.
  - This guarantees at least one p_pop-low cycle between runs. Upstream counts falling edges of p_pop: 4 runs -> par+1 after the tile.
- Pattern tile drain is atomic: 4 runs, 16 words, not interruptible by attribute traffic or by drain_en falling.
- A_POP: a_pop=1 for exactly 4 consecutive cycles, capturing a_data into lanes 0..3. Go to A_WR. This single run gives upstream aar += 4.
- A_WR: req=1, addr=attr_q. On ack, set last_served=ATTR and go to IDLE.
- vram_wr_addr/vram_wr_data are registered and stable from the first req cycle until the ack cycle.
- Ack latency: any number of cycles ≥0 after req is legal. An ack while req=0 is ignored.
- Minimum turnaround: one IDLE cycle between consecutive drains.
- Lane capture rule: the word sampled in pop cycle k is the FIFO head at that cycle. The FIFO advances on the following edge.
- No pop is ever issued unless the corresponding full flag was seen in IDLE. p_full/a_full changing during a drain is ignored.

Decomposition:
- Package xgmm_pkg holds:
  - state enum xgmm_wr_state_t {IDLE,P_POP,P_WR,A_POP,A_WR}
  - src_t {PAT,ATTR}
  - localparams: WORDS_PER_RUN=4, RUNS_PER_TILE=4
- One sub-module: xgmm_burst_pack, a 4x16 -> 64 lane capture register with a lane index and a load enable.

Test Plan:
- p_full=1, drain_en=1, par=12'h005, FIFO words 0x1000..0x100F -> four writes at addresses 0x50,0x54,0x58,0x5C. Data of the first write = 64'h1003_1002_1001_1000. Each p_pop run is 4 cycles wide with gaps ≥1 cycle.
- a_full=1, aar=15'h0102 -> a single 4-cycle a_pop run, then a write at 0x010100 with the 4 captured words.
- p_full & a_full asserted together from reset -> pattern tile drained first, then attribute. Repeat -> order alternates.
- vram_wr_ack delayed 5 cycles -> req, addr and data held constant for 5 cycles, and no pop occurs while waiting.
- drain_en=0 with p_full=1 -> no pops. Dropping drain_en during the 2nd run -> tile still completes all 4 runs.
- rst pulsed during P_POP word 2 -> p_pop, req and busy go to 0 immediately and the state is IDLE. No write is issued afterwards until full is reasserted.
